// File: rtl/mode_transition_ctrl.sv
// rtl/mode_transition_ctrl.sv - operating-mode sequencer with legal-transition check, dwell and lockout
//
// Ports:
//   clk, rst_n          clock (posedge) and synchronous active-low reset
//   req_valid/req_mode  mode-change request (3-bit mode)
//   req_ready           a request can be accepted this cycle
//   clr_lockout         releases lockout; ignored outside lockout
//   mode_out            current mode, registered
//   busy                dwell in progress
//   err                 one-cycle pulse after a rejected request or a corrupted mode
//   lockout             controller is locked out
//   illegal_total       (MODE_AUDIT_EN) saturating count of rejected requests
//   last_bad_mode       (MODE_AUDIT_EN) req_mode of the latest rejected request
//
// Optional feature macro: MODE_AUDIT_EN
module mode_transition_ctrl #(
    parameter int DWELL_CYCLES = 4,
    parameter int MAX_ILLEGAL  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [2:0] req_mode,
    output logic       req_ready,
    input  logic       clr_lockout,
    output logic [2:0] mode_out,
    output logic       busy,
    output logic       err,
`ifdef MODE_AUDIT_EN
    output logic [7:0] illegal_total,
    output logic [2:0] last_bad_mode,
`endif
    output logic       lockout
);

    localparam logic [2:0] M_IDLE     = 3'd0;
    localparam logic [2:0] M_INIT     = 3'd1;
    localparam logic [2:0] M_RUN      = 3'd2;
    localparam logic [2:0] M_PAUSE    = 3'd3;
    localparam logic [2:0] M_SHUTDOWN = 3'd4;

    // The counter is reloaded with DWELL_CYCLES-1 and the state leaves DWELL
    // on the edge where it reads zero, giving exactly DWELL_CYCLES busy cycles.
    localparam logic [7:0] DWELL_LOAD = 8'(DWELL_CYCLES - 1);
    localparam logic [3:0] ILL_LIMIT  = 4'(MAX_ILLEGAL);

    typedef enum logic [1:0] {
        S_READY = 2'd0,
        S_DWELL = 2'd1,
        S_LOCK  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] mode_q, mode_d;
    logic [7:0] dwell_q, dwell_d;
    logic [3:0] ill_q, ill_d;
    logic       err_q, err_d;
    logic       reject;

    function automatic logic legal_step(input logic [2:0] from, input logic [2:0] to);
        logic ok;
        ok = 1'b0;
        case (from)
            M_IDLE:     ok = (to == M_INIT);
            M_INIT:     ok = (to == M_RUN)   || (to == M_IDLE);
            M_RUN:      ok = (to == M_PAUSE) || (to == M_SHUTDOWN);
            M_PAUSE:    ok = (to == M_RUN)   || (to == M_SHUTDOWN);
            M_SHUTDOWN: ok = (to == M_IDLE);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_READY;
            mode_q  <= M_IDLE;
            dwell_q <= 8'd0;
            ill_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dwell_q <= dwell_d;
            ill_q   <= ill_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        dwell_d = dwell_q;
        ill_d   = ill_q;
        err_d   = 1'b0;
        reject  = 1'b0;
        if (mode_q > M_SHUTDOWN) begin
            // Corrupted mode register: park safely regardless of state or inputs.
            state_d = S_LOCK;
            mode_d  = M_SHUTDOWN;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                S_READY: begin
                    if (req_valid) begin
                        if (req_mode == mode_q) begin
                            ill_d = 4'd0;
                        end else if (legal_step(mode_q, req_mode)) begin
                            mode_d  = req_mode;
                            ill_d   = 4'd0;
                            dwell_d = DWELL_LOAD;
                            state_d = S_DWELL;
                        end else begin
                            reject = 1'b1;
                            err_d  = 1'b1;
                            ill_d  = (ill_q == 4'hF) ? ill_q : ill_q + 4'd1;
                            if (ill_d >= ILL_LIMIT) begin
                                state_d = S_LOCK;
                                mode_d  = M_SHUTDOWN;
                            end
                        end
                    end
                end
                S_DWELL: begin
                    if (dwell_q == 8'd0) begin
                        state_d = S_READY;
                    end else begin
                        dwell_d = dwell_q - 8'd1;
                    end
                end
                S_LOCK: begin
                    mode_d = M_SHUTDOWN;
                    if (clr_lockout) begin
                        mode_d  = M_IDLE;
                        ill_d   = 4'd0;
                        state_d = S_READY;
                    end
                end
                default: begin
                    state_d = S_LOCK;
                    mode_d  = M_SHUTDOWN;
                end
            endcase
        end
    end

`ifdef MODE_AUDIT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_total <= 8'd0;
            last_bad_mode <= 3'd0;
        end else if (reject) begin
            if (illegal_total != 8'hFF) begin
                illegal_total <= illegal_total + 8'd1;
            end
            last_bad_mode <= req_mode;
        end
    end
`endif

    assign req_ready = (state_q == S_READY);
    assign busy      = (state_q == S_DWELL);
    assign lockout   = (state_q == S_LOCK);
    assign mode_out  = mode_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mode_transition_ctrl.sv
// tb/tb_mode_transition_ctrl.sv - directed self-checking bench for mode_transition_ctrl
module tb_mode_transition_ctrl;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic [2:0] req_mode;
    logic       req_ready;
    logic       clr_lockout;
    logic [2:0] mode_out;
    logic       busy;
    logic       err;
    logic       lockout;
`ifdef MODE_AUDIT_EN
    logic [7:0] illegal_total;
    logic [2:0] last_bad_mode;
`endif

    int n_checks;
    int n_errors;

    mode_transition_ctrl #(.DWELL_CYCLES(4), .MAX_ILLEGAL(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_mode     (req_mode),
        .req_ready    (req_ready),
        .clr_lockout  (clr_lockout),
        .mode_out     (mode_out),
        .busy         (busy),
        .err          (err),
`ifdef MODE_AUDIT_EN
        .illegal_total(illegal_total),
        .last_bad_mode(last_bad_mode),
`endif
        .lockout      (lockout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one request for a single edge; outputs are sampled afterwards.
    task automatic do_req(input logic [2:0] m);
        req_valid = 1'b1;
        req_mode  = m;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(req_ready), 32'd1);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_mode    = 3'd0;
        clr_lockout = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        check("rst_mode",  32'(mode_out),  32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_err",   32'(err),       32'd0);
        check("rst_lock",  32'(lockout),   32'd0);

        // Same-mode request is a no-op.
        do_req(3'd0);
        check("same_mode", 32'(mode_out),  32'd0);
        check("same_rdy",  32'(req_ready), 32'd1);
        check("same_err",  32'(err),       32'd0);

        // IDLE->INIT, dwell of 4 cycles; a request held during dwell is ignored.
        req_valid = 1'b1;
        req_mode  = 3'd1;
        @(negedge clk);
        req_mode  = 3'd2;
        check("init_mode", 32'(mode_out),  32'd1);
        check("init_busy", 32'(busy),      32'd1);
        check("init_rdy",  32'(req_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("dwell_busy", 32'(busy), 32'd1);
            check("dwell_hold", 32'(mode_out), 32'd1);
        end
        @(negedge clk);
        req_valid = 1'b0;
        check("dwell_end_rdy",  32'(req_ready), 32'd1);
        check("dwell_end_busy", 32'(busy),      32'd0);
        check("dwell_end_mode", 32'(mode_out),  32'd1);

        // INIT->RUN, then illegal RUN->IDLE.
        do_req(3'd2);
        wait_ready("run_ready");
        check("run_mode", 32'(mode_out), 32'd2);
        do_req(3'd0);
        check("bad_err",  32'(err),       32'd1);
        check("bad_mode", 32'(mode_out),  32'd2);
        check("bad_rdy",  32'(req_ready), 32'd1);
        @(negedge clk);
        check("bad_err_pulse", 32'(err), 32'd0);

        // RUN->SHUTDOWN->IDLE (legal, clears the illegal count).
        do_req(3'd4);
        wait_ready("shut_ready");
        do_req(3'd0);
        wait_ready("idle_ready");
        check("idle_mode", 32'(mode_out), 32'd0);

        // Three requests for 6 -> lockout on the third.
        do_req(3'd6);
        check("ill1_err",  32'(err),     32'd1);
        check("ill1_lock", 32'(lockout), 32'd0);
        do_req(3'd6);
        check("ill2_err",  32'(err),     32'd1);
        check("ill2_lock", 32'(lockout), 32'd0);
        do_req(3'd6);
        check("ill3_err",  32'(err),       32'd1);
        check("ill3_lock", 32'(lockout),   32'd1);
        check("ill3_mode", 32'(mode_out),  32'd4);
        check("ill3_rdy",  32'(req_ready), 32'd0);
        @(negedge clk);
        check("lock_hold", 32'(mode_out), 32'd4);

        // clr_lockout beats a simultaneous request.
        clr_lockout = 1'b1;
        req_valid   = 1'b1;
        req_mode    = 3'd1;
        @(negedge clk);
        clr_lockout = 1'b0;
        req_valid   = 1'b0;
        check("clr_mode", 32'(mode_out),  32'd0);
        check("clr_lock", 32'(lockout),   32'd0);
        check("clr_rdy",  32'(req_ready), 32'd1);

        // Two illegal, one legal, two illegal -> no lockout.
        do_req(3'd7);
        do_req(3'd3);
        do_req(3'd1);
        wait_ready("mix_ready");
        do_req(3'd4);
        do_req(3'd3);
        check("mix_err",  32'(err),      32'd1);
        check("mix_lock", 32'(lockout),  32'd0);
        check("mix_mode", 32'(mode_out), 32'd1);

        // Reset in the middle of a dwell.
        do_req(3'd2);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_mode", 32'(mode_out),  32'd0);
        check("mid_rst_busy", 32'(busy),      32'd0);
        check("mid_rst_rdy",  32'(req_ready), 32'd1);
        check("mid_rst_lock", 32'(lockout),   32'd0);

`ifdef MODE_AUDIT_EN
        check("aud_total0", 32'(illegal_total), 32'd0);
        do_req(3'd5);
        check("aud_total1", 32'(illegal_total), 32'd1);
        check("aud_last",   32'(last_bad_mode), 32'd5);
`endif

        // Corrupt the mode register directly.
        dut.mode_q = 3'd7;
        @(negedge clk);
        check("corr_lock", 32'(lockout),  32'd1);
        check("corr_mode", 32'(mode_out), 32'd4);
        check("corr_err",  32'(err),      32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mode_transition_ctrl.md
Name: mode_transition_ctrl

Overview:
- Sequences the 3-bit operating-mode register for downstream datapath blocks.
- Accepts mode-change requests from user logic over a valid/ready handshake.
- Applies only legal transitions and enforces a settle (dwell) period after each change.
- Never lets the mode register hold an undefined encoding. Repeated illegal requests force a safe lockout that only an explicit clear releases.

Parameters:
- DWELL_CYCLES, 4, cycles req_ready stays low after a legal mode change; legal range 1..255.
- MAX_ILLEGAL, 3, consecutive illegal requests that trigger lockout; legal range 1..15.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- req_valid  input  1  request present.
- req_mode  input  3  requested mode.
- req_ready  output  1  controller can accept a request this cycle.
- clr_lockout  input  1  releases lockout; ignored outside lockout.
- mode_out  output  3  current mode, registered.
- busy  output  1  dwell in progress.
- err  output  1  one-cycle pulse on rejected request.
- lockout  output  1  controller is in lockout.

Behaviour:
- Mode encodings: IDLE=0, INIT=1, RUN=2, PAUSE=3, SHUTDOWN=4. Encodings 5-7 are illegal, both as requests and as mode_out values.
- Legal transitions:
  - IDLE->INIT
  - INIT->RUN, INIT->IDLE
  - RUN->PAUSE, RUN->SHUTDOWN
  - PAUSE->RUN, PAUSE->SHUTDOWN
  - SHUTDOWN->IDLE
  - Every other pair, and any request for 5-7, is illegal.
- Reset (rst_n low at posedge) values: ctrl state=READY, mode_out=0, req_ready=1, busy=0, err=0, lockout=0, dwell counter=0, illegal counter=0. Reset overrides everything, including mid-dwell and lockout.
- Controller states: READY, DWELL, LOCK. Unused state encodings go to LOCK on the next edge.
- Accept occurs when req_valid && req_ready at a posedge. Requests while req_ready=0 are ignored and not queued.
- READY, legal accept:
  - mode_out takes req_mode at that edge.
  - Illegal counter clears.
  - Go to DWELL: busy=1, req_ready=0 for exactly DWELL_CYCLES cycles.
  - Then READY: busy=0, req_ready=1.
- READY, same-mode request: accepted as a no-op. mode_out unchanged, no dwell, err=0, illegal counter clears.
- READY, illegal accept:
  - mode_out unchanged.
  - err=1 for the following cycle only.
  - Illegal counter increments (saturating).
  - If the counter reaches MAX_ILLEGAL: enter LOCK on the same edge.
- LOCK:
  - mode_out=4 (SHUTDOWN), lockout=1, req_ready=0, busy=0.
  - clr_lockout high at a posedge: mode_out=0, illegal counter=0, go READY.
  - clr_lockout in any other state has no effect.
- Integrity check: if mode_out ever holds 5-7 (corruption), the next edge forces LOCK with err=1.
- Simultaneous events:
  - rst_n beats all other inputs.
  - In LOCK, clr_lockout beats any pending req_valid; the request is not accepted that cycle.

Optional Feature:
- Macro MODE_AUDIT_EN.
- When defined, adds two ports:
  - output 8-bit illegal_total: saturating count of all rejected requests since reset; never cleared by clr_lockout.
  - output 3-bit last_bad_mode: req_mode of the most recent rejected request.
  - Both reset to 0.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset, then req 1 at cycle 2 -> mode_out=1 after the edge; req_ready=0 and busy=1 for 4 cycles; req_ready=1 at cycle 7.
- From RUN(2), req 0 -> err pulses 1 cycle, mode_out stays 2, req_ready stays 1.
- From IDLE, three consecutive requests of 6 -> err pulses on each; after the third, lockout=1 and mode_out=4. Then clr_lockout=1 -> mode_out=0, lockout=0, req_ready=1.
- Two illegal requests, then a legal IDLE->INIT, then two more illegal -> no lockout, because the counter was cleared by the legal request.
- Request held during dwell -> ignored. rst_n=0 mid-dwell -> mode_out=0, busy=0, req_ready=1 next cycle.
- Force mode_out to 7 by bench deposit -> next edge LOCK, mode_out=4, err=1. With MODE_AUDIT_EN, illegal_total=1 after one rejected request of 5 and last_bad_mode=5.
